// File: rtl/exc_dispatch.sv
// exc_dispatch: pipeline-side exception and interrupt dispatcher.
// Takes exception flags from the commit stage, interrupt lines and eret.
// Presents one event to CP0 for a single cycle, flushes the pipeline,
// then holds a redirect to the exception vector or EPC until fetch accepts it.
// Optional build macro EXC_DISPATCH_IRQ_SYNC_EN adds a 2-flop synchroniser
// on i_irq. Without it, i_irq is assumed to be synchronous already.
module exc_dispatch #(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic        i_commit_in_delay_slot,
    input  logic        i_adel_if,
    input  logic        i_ri,
    input  logic        i_syscall,
    input  logic        i_break,
    input  logic        i_ov,
    input  logic        i_adel_mem,
    input  logic        i_ades_mem,
    input  logic        i_eret,
    input  logic [4:0]  i_irq,
    input  logic        i_timer_int,
    input  logic        i_exl,
    input  logic [31:0] i_epc,
    input  logic        i_redirect_ready,
    output logic [4:0]  o_except_cause,
    output logic [5:0]  o_int,
    output logic [31:0] o_current_pc,
    output logic        o_is_in_delay_slot,
    output logic        o_is_eret,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    // Cause codes presented to CP0. NOP means that no synchronous cause is present.
    localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1f;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;

    logic [1:0]  r_state;
    logic [4:0]  r_cause;
    logic [5:0]  r_int;
    logic [31:0] r_pc;
    logic        r_ds;
    logic        r_eret;
    logic [31:0] r_target;

    logic [4:0]  w_irq;
    logic [5:0]  w_int_vec;
    logic        w_int_pend;
    logic [4:0]  w_sel_cause;
    logic        w_sel_eret;
    logic        w_sel_any;
    logic        w_trigger;

`ifdef EXC_DISPATCH_IRQ_SYNC_EN
    logic [4:0] r_irq_meta;
    logic [4:0] r_irq_sync;

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq_meta <= '0;
            r_irq_sync <= '0;
        end else begin
            // NOTE: the non-blocking assignments below make both flops sample
            // on the same edge. With blocking assignments, the two stages
            // would collapse into one.
            r_irq_meta <= i_irq;
            r_irq_sync <= r_irq_meta;
        end
    end

    assign w_irq = r_irq_sync;
`else
    assign w_irq = i_irq;
`endif

    assign w_int_vec  = {i_timer_int, w_irq};
    assign w_int_pend = !i_exl && (w_int_vec != 6'd0);

    // Priority select of the commit-stage event: interrupt, exceptions, then eret.
    always_comb begin
        // NOTE: default every output first. Otherwise a path that leaves one
        // unassigned infers a latch.
        w_sel_cause = EXC_CAUSE_NOP;
        w_sel_eret  = 1'b0;
        w_sel_any   = 1'b1;
        if (w_int_pend)        w_sel_cause = EXC_CAUSE_NOP;
        else if (i_adel_if)    w_sel_cause = EXC_CAUSE_ADEL;
        else if (i_ri)         w_sel_cause = EXC_CAUSE_RI;
        else if (i_syscall)    w_sel_cause = EXC_CAUSE_SYS;
        else if (i_break)      w_sel_cause = EXC_CAUSE_BP;
        else if (i_ov)         w_sel_cause = EXC_CAUSE_OV;
        else if (i_adel_mem)   w_sel_cause = EXC_CAUSE_ADEL;
        else if (i_ades_mem)   w_sel_cause = EXC_CAUSE_ADES;
        else if (i_eret)       w_sel_eret  = 1'b1;
        else                   w_sel_any   = 1'b0;
    end

    assign w_trigger = (r_state == S_IDLE) && i_commit_valid && w_sel_any;

    // Sequencer: IDLE -> COMMIT -> FLUSH -> REDIRECT (held until accepted).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_trigger) r_state <= S_COMMIT;
                S_COMMIT:   r_state <= S_FLUSH;
                S_FLUSH:    r_state <= S_REDIRECT;
                S_REDIRECT: if (i_redirect_ready) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the event on trigger. Resolve the redirect target while in FLUSH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cause  <= EXC_CAUSE_NOP;
            r_int    <= '0;
            r_pc     <= '0;
            r_ds     <= 1'b0;
            r_eret   <= 1'b0;
            r_target <= '0;
        end else begin
            if (w_trigger) begin
                r_cause <= w_sel_cause;
                r_int   <= w_int_pend ? w_int_vec : 6'd0;
                r_pc    <= i_commit_pc;
                r_ds    <= i_commit_in_delay_slot;
                r_eret  <= w_sel_eret;
            end
            if (r_state == S_FLUSH) begin
                r_target <= r_eret ? i_epc : EXC_VECTOR;
            end
        end
    end

    // Outputs are decoded from the state, so an asynchronous reset clears them at once.
    assign o_except_cause     = (r_state == S_COMMIT) ? r_cause : EXC_CAUSE_NOP;
    assign o_int              = (r_state == S_COMMIT) ? r_int   : 6'd0;
    assign o_current_pc       = (r_state == S_COMMIT) ? r_pc    : 32'd0;
    assign o_is_in_delay_slot = (r_state == S_COMMIT) && r_ds;
    assign o_is_eret          = (r_state == S_COMMIT) && r_eret;
    assign o_stall            = (r_state != S_IDLE);
    assign o_flush            = (r_state == S_FLUSH);
    assign o_redirect_valid   = (r_state == S_REDIRECT);
    assign o_redirect_pc      = (r_state == S_REDIRECT) ? r_target : 32'd0;

endmodule

// File: tb/tb_exc_dispatch.sv
// tb_exc_dispatch: self-checking bench for exc_dispatch.
// Directed scenarios plus randomized events, checked against a priority-list model.
module tb_exc_dispatch;

    localparam logic [31:0] VEC = 32'h0040_0004;
    localparam logic [4:0]  NOP = 5'h1f;
`ifdef EXC_DISPATCH_IRQ_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    logic        clk;
    logic        resetn;
    logic        i_commit_valid;
    logic [31:0] i_commit_pc;
    logic        i_commit_in_delay_slot;
    logic        i_adel_if, i_ri, i_syscall, i_break, i_ov, i_adel_mem, i_ades_mem;
    logic        i_eret;
    logic [4:0]  i_irq;
    logic        i_timer_int;
    logic        i_exl;
    logic [31:0] i_epc;
    logic        i_redirect_ready;
    logic [4:0]  o_except_cause;
    logic [5:0]  o_int;
    logic [31:0] o_current_pc;
    logic        o_is_in_delay_slot;
    logic        o_is_eret;
    logic        o_stall;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    exc_dispatch #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .resetn(resetn),
        .i_commit_valid(i_commit_valid), .i_commit_pc(i_commit_pc),
        .i_commit_in_delay_slot(i_commit_in_delay_slot),
        .i_adel_if(i_adel_if), .i_ri(i_ri), .i_syscall(i_syscall), .i_break(i_break),
        .i_ov(i_ov), .i_adel_mem(i_adel_mem), .i_ades_mem(i_ades_mem),
        .i_eret(i_eret), .i_irq(i_irq), .i_timer_int(i_timer_int), .i_exl(i_exl),
        .i_epc(i_epc), .i_redirect_ready(i_redirect_ready),
        .o_except_cause(o_except_cause), .o_int(o_int), .o_current_pc(o_current_pc),
        .o_is_in_delay_slot(o_is_in_delay_slot), .o_is_eret(o_is_eret),
        .o_stall(o_stall), .o_flush(o_flush),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All observable outputs packed into one word so that each phase is a single comparison.
    logic [79:0] obs;
    assign obs = {o_except_cause, o_int, o_current_pc, o_is_in_delay_slot, o_is_eret,
                  o_stall, o_flush, o_redirect_valid, o_redirect_pc};

    function automatic logic [79:0] pk(input logic [4:0] c, input logic [5:0] iv,
                                       input logic [31:0] pc, input logic ds, input logic er,
                                       input logic st, input logic fl, input logic rv,
                                       input logic [31:0] rpc);
        return {c, iv, pc, ds, er, st, fl, rv, rpc};
    endfunction

    function automatic logic [79:0] idle_word();
        return pk(NOP, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endfunction

    // Reference model. Flags are ordered {adel_if, ri, syscall, break, ov, adel_mem, ades_mem}.
    function automatic void model(input logic [6:0] f, input logic er, input logic [5:0] iv,
                                  input logic exl, output logic [4:0] c, output logic [5:0] io,
                                  output logic e, output logic any);
        logic [4:0] codes [7];
        logic found;
        codes = '{5'd4, 5'd10, 5'd8, 5'd9, 5'd12, 5'd4, 5'd5};
        c = NOP; io = 6'd0; e = 1'b0; any = 1'b1; found = 1'b0;
        if (!exl && iv != 6'd0) begin
            io = iv;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (!found && f[6-i]) begin
                    c = codes[i];
                    found = 1'b1;
                end
            end
            if (!found) begin
                if (er) e = 1'b1;
                else    any = 1'b0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        i_commit_valid = 0; i_commit_pc = 0; i_commit_in_delay_slot = 0;
        {i_adel_if, i_ri, i_syscall, i_break, i_ov, i_adel_mem, i_ades_mem} = 7'd0;
        i_eret = 0;
    endtask

    // Set up the interrupt, EXL and EPC inputs, then let them settle through the synchroniser.
    task automatic setup_env(input logic [4:0] irq, input logic tmr, input logic exl,
                             input logic [31:0] epc);
        i_irq = irq; i_timer_int = tmr; i_exl = exl; i_epc = epc;
        repeat (3) step();
    endtask

    task automatic drive_commit(input logic cv, input logic [6:0] f, input logic er,
                                input logic [31:0] pc, input logic ds);
        step();
        i_commit_valid = cv; i_commit_pc = pc; i_commit_in_delay_slot = ds;
        {i_adel_if, i_ri, i_syscall, i_break, i_ov, i_adel_mem, i_ades_mem} = f;
        i_eret = er;
    endtask

    // Follows one dispatch from COMMIT to IDLE. Ready is held low for `delay` redirect cycles.
    task automatic expect_dispatch(input logic [4:0] c, input logic [5:0] iv,
                                   input logic [31:0] pc, input logic ds, input logic er,
                                   input logic [31:0] tgt, input int delay, input string name);
        logic [79:0] exp;
        step();
        clear_commit();
        @(negedge clk);
        exp = pk(c, iv, pc, ds, er, 1'b1, 1'b0, 1'b0, 32'd0);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s commit: got %h want %h", name, obs, exp);
        end
        step();
        @(negedge clk);
        exp = pk(NOP, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s flush: got %h want %h", name, obs, exp);
        end
        exp = pk(NOP, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, tgt);
        for (int d = 0; d <= delay; d++) begin
            step();
            i_redirect_ready = (d == delay);
            if (d == 0) i_epc = ~i_epc;
            @(negedge clk);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s redirect[%0d]: got %h want %h", name, d, obs, exp);
            end
        end
        step();
        i_redirect_ready = 0;
        @(negedge clk);
        n_vec++;
        if (obs !== idle_word()) begin
            n_err++;
            $display("FAIL %s idle: got %h want %h", name, obs, idle_word());
        end
    endtask

    task automatic expect_none(input string name);
        step();
        clear_commit();
        @(negedge clk);
        n_vec++;
        if (obs !== idle_word()) begin
            n_err++;
            $display("FAIL %s no_dispatch: got %h want %h", name, obs, idle_word());
        end
    endtask

    task automatic test_reset();
        resetn = 0; clear_commit();
        i_irq = 0; i_timer_int = 0; i_exl = 0; i_epc = 0; i_redirect_ready = 0;
        #2;
        n_vec++;
        if (obs !== idle_word()) begin
            n_err++;
            $display("FAIL reset_values: got %h want %h", obs, idle_word());
        end
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_syscall();
        setup_env(5'd0, 1'b0, 1'b0, 32'd0);
        i_redirect_ready = 1;
        drive_commit(1'b1, 7'b0010000, 1'b0, 32'h0040_0100, 1'b0);
        expect_dispatch(5'd8, 6'd0, 32'h0040_0100, 1'b0, 1'b0, VEC, 0, "syscall");
    endtask

    task automatic test_int_priority();
        setup_env(5'b00100, 1'b0, 1'b0, 32'd0);
        drive_commit(1'b1, 7'b0100100, 1'b0, 32'h0040_0120, 1'b0);
        expect_dispatch(NOP, 6'b000100, 32'h0040_0120, 1'b0, 1'b0, VEC, 0, "int_over_exc");
        setup_env(5'b00100, 1'b0, 1'b1, 32'd0);
        drive_commit(1'b1, 7'b0100100, 1'b0, 32'h0040_0140, 1'b0);
        expect_dispatch(5'd10, 6'd0, 32'h0040_0140, 1'b0, 1'b0, VEC, 0, "exl_masks_int");
        setup_env(5'd0, 1'b0, 1'b0, 32'h0040_0230);
        drive_commit(1'b1, 7'b0000010, 1'b1, 32'h0040_0150, 1'b0);
        expect_dispatch(5'd4, 6'd0, 32'h0040_0150, 1'b0, 1'b0, VEC, 0, "exc_over_eret");
    endtask

    task automatic test_eret();
        setup_env(5'd0, 1'b0, 1'b1, 32'h0040_0230);
        drive_commit(1'b1, 7'd0, 1'b1, 32'h0040_0300, 1'b0);
        expect_dispatch(NOP, 6'd0, 32'h0040_0300, 1'b0, 1'b1, 32'h0040_0230, 0, "eret");
    endtask

    task automatic test_back_to_back_stall();
        setup_env(5'd0, 1'b0, 1'b0, 32'd0);
        drive_commit(1'b1, 7'b0000010, 1'b0, 32'h0040_0204, 1'b1);
        expect_dispatch(5'd4, 6'd0, 32'h0040_0204, 1'b1, 1'b0, VEC, 3, "ds_adel_mem");
    endtask

    task automatic test_reset_mid_flush();
        setup_env(5'd0, 1'b0, 1'b0, 32'd0);
        i_redirect_ready = 1;
        drive_commit(1'b1, 7'b0010000, 1'b0, 32'h0040_0400, 1'b0);
        step();
        clear_commit();
        step();
        #2;
        resetn = 0;
        #1;
        n_vec++;
        if (obs !== idle_word()) begin
            n_err++;
            $display("FAIL reset_in_flush: got %h want %h", obs, idle_word());
        end
        #1;
        resetn = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== idle_word()) begin
                n_err++;
                $display("FAIL reset_no_redirect[%0d]: got %h want %h", k, obs, idle_word());
            end
        end
        i_redirect_ready = 0;
    endtask

    task automatic test_irq_latency();
        int lat;
        logic found;
        setup_env(5'd0, 1'b0, 1'b0, 32'd0);
        step();
        i_commit_valid = 1; i_commit_pc = 32'h0040_0500; i_irq = 5'b00001;
        lat = 0; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (o_stall === 1'b1) found = 1;
        end
        n_vec++;
        if (!found || lat != 2 + SYNC_EXTRA) begin
            n_err++;
            $display("FAIL irq_latency: got %0d (seen=%0d) want %0d", lat, found, 2 + SYNC_EXTRA);
        end
        n_vec++;
        if ({o_int, o_except_cause} !== {6'b000001, NOP}) begin
            n_err++;
            $display("FAIL irq0_commit: got %h want %h", {o_int, o_except_cause}, {6'b000001, NOP});
        end
        step();
        clear_commit();
        i_irq = 0; i_redirect_ready = 1;
        repeat (2) step();
        i_redirect_ready = 0;
        @(negedge clk);
        n_vec++;
        if (obs !== idle_word()) begin
            n_err++;
            $display("FAIL irq_return_idle: got %h want %h", obs, idle_word());
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [6:0]  f;
        logic [4:0]  irq, c;
        logic [5:0]  io;
        logic        tmr, exl, er, cv, ds, e, any;
        logic [31:0] pc, epc;
        int          delay;
        for (int it = 0; it < 60; it++) begin
            r = $urandom;
            irq = ($urandom_range(0, 2) == 0) ? r[4:0] : 5'd0;
            tmr = ($urandom_range(0, 5) == 0);
            exl = r[8];
            er  = ($urandom_range(0, 3) == 0);
            cv  = ($urandom_range(0, 7) != 0);
            ds  = r[9];
            for (int b = 0; b < 7; b++) f[b] = ($urandom_range(0, 4) == 0);
            pc  = $urandom & 32'hffff_fffc;
            epc = $urandom & 32'hffff_fffc;
            delay = $urandom_range(0, 3);
            setup_env(irq, tmr, exl, epc);
            model(f, er, {tmr, irq}, exl, c, io, e, any);
            drive_commit(cv, f, er, pc, ds);
            if (cv && any)
                expect_dispatch(c, io, pc, ds, e, e ? epc : VEC, delay, "random");
            else
                expect_none("random");
        end
        i_irq = 0; i_timer_int = 0;
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_int_priority();
        test_eret();
        test_back_to_back_stall();
        test_reset_mid_flush();
        test_irq_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
